// File: rtl/axi_sram_slave.sv
// AXI3-style slave bridging single-outstanding INCR bursts onto a 1-cycle-latency SRAM.
// Optional feature: define AXI_SRAM_SLAVE_DECERR_EN to answer out-of-range addresses with DECERR.
module axi_sram_slave #(
  parameter int SRAM_AW = 14
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [7:0]         AWID,
  input  logic [31:0]        AWADDR,
  input  logic [3:0]         AWLEN,
  input  logic [2:0]         AWSIZE,
  input  logic [1:0]         AWBURST,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [31:0]        WDATA,
  input  logic [3:0]         WSTRB,
  input  logic               WLAST,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [7:0]         BID,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [7:0]         ARID,
  input  logic [31:0]        ARADDR,
  input  logic [3:0]         ARLEN,
  input  logic [2:0]         ARSIZE,
  input  logic [1:0]         ARBURST,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [7:0]         RID,
  output logic [31:0]        RDATA,
  output logic [1:0]         RRESP,
  output logic               RLAST,
  output logic               RVALID,
  input  logic               RREADY,
  output logic               CEB,
  output logic               WEB,
  output logic [31:0]        BWEB,
  output logic [SRAM_AW-1:0] A,
  output logic [31:0]        DI,
  input  logic [31:0]        DO
);

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  localparam logic [SRAM_AW-1:0] ADDR_ONE = 1;

  state_t             state_q, state_d;
  logic [7:0]         id_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [3:0]         len_q, cnt_q;
  logic               decerr_q, rd_first_q;
  logic               aw_acc, ar_acc, w_hs, r_hs, rd_adv;
  logic               aw_decerr, ar_decerr;
  logic               sram_cs, sram_we;
  logic               vld_p1, rd_fresh_p1;
  logic [31:0]        rdata_hold_p1;
  logic               unused_ok;

  function automatic logic [31:0] strb_to_bweb(input logic [3:0] strb);
    logic [31:0] mask;
    for (int n = 0; n < 4; n++) mask[8*n +: 8] = {8{~strb[n]}};
    return mask;
  endfunction

`ifdef AXI_SRAM_SLAVE_DECERR_EN
  assign aw_decerr = |AWADDR[31:SRAM_AW+2];
  assign ar_decerr = |ARADDR[31:SRAM_AW+2];
`else
  assign aw_decerr = 1'b0;
  assign ar_decerr = 1'b0;
`endif

  // Size/burst type and sub-word address bits carry no information for this slave.
  assign unused_ok = &{1'b0, AWSIZE, AWBURST, ARSIZE, ARBURST, AWADDR[1:0], ARADDR[1:0],
                       AWADDR[31:SRAM_AW+2], ARADDR[31:SRAM_AW+2]};

  always_comb begin
    state_d = state_q;
    AWREADY = 1'b0;
    ARREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    aw_acc  = 1'b0;
    ar_acc  = 1'b0;
    w_hs    = 1'b0;
    r_hs    = 1'b0;
    rd_adv  = 1'b0;
    sram_cs = 1'b0;
    sram_we = 1'b0;
    case (state_q)
      IDLE: begin
        // Write wins a simultaneous request, so AR is refused while AW is pending.
        AWREADY = ARESETn;
        ARREADY = ARESETn & ~AWVALID;
        aw_acc  = AWVALID & AWREADY;
        ar_acc  = ARVALID & ARREADY;
        if (aw_acc)      state_d = WR;
        else if (ar_acc) state_d = RD;
      end
      RD: begin
        r_hs = vld_p1 & RREADY;
        if (rd_first_q) begin
          sram_cs = ~decerr_q;
        end else if (r_hs) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            rd_adv  = 1'b1;
            sram_cs = ~decerr_q;
          end
        end
      end
      WR: begin
        WREADY  = 1'b1;
        w_hs    = WVALID;
        sram_cs = WVALID & ~decerr_q;
        sram_we = 1'b1;
        if (w_hs && WLAST) state_d = WRESP;
      end
      WRESP: begin
        BVALID = 1'b1;
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign CEB  = ~sram_cs;
  assign WEB  = ~(sram_cs & sram_we);
  assign BWEB = (sram_cs & sram_we) ? strb_to_bweb(WSTRB) : '1;
  assign DI   = (sram_cs & sram_we) ? WDATA : '0;
  assign A    = rd_adv ? addr_q + ADDR_ONE : addr_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      id_q       <= '0;
      cnt_q      <= '0;
      decerr_q   <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_acc) begin
        id_q     <= AWID;
        cnt_q    <= '0;
        decerr_q <= aw_decerr;
      end else if (ar_acc) begin
        id_q       <= ARID;
        cnt_q      <= '0;
        decerr_q   <= ar_decerr;
        rd_first_q <= 1'b1;
      end else if (rd_first_q) begin
        rd_first_q <= 1'b0;
      end
      if (w_hs || rd_adv) cnt_q <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_acc) begin
      addr_q <= AWADDR[SRAM_AW+1:2];
      len_q  <= AWLEN;
    end else if (ar_acc) begin
      addr_q <= ARADDR[SRAM_AW+1:2];
      len_q  <= ARLEN;
    end else if (w_hs || rd_adv) begin
      addr_q <= addr_q + ADDR_ONE;
    end
  end

  // Stage p1: SRAM read data returns; DO is parked in the hold register across R stalls.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vld_p1        <= 1'b0;
      rd_fresh_p1   <= 1'b0;
      rdata_hold_p1 <= '0;
    end else begin
      rd_fresh_p1 <= sram_cs & ~sram_we;
      if (rd_fresh_p1) rdata_hold_p1 <= DO;
      if (state_q == RD && rd_first_q) vld_p1 <= 1'b1;
      else if (r_hs && cnt_q == len_q) vld_p1 <= 1'b0;
    end
  end

  assign RVALID = vld_p1;
  assign RLAST  = vld_p1 & (cnt_q == len_q);
  assign RID    = id_q;
  assign BID    = id_q;
  assign RDATA  = decerr_q ? '0 : (rd_fresh_p1 ? DO : rdata_hold_p1);
  assign RRESP  = (vld_p1 & decerr_q) ? 2'b11 : 2'b00;
  assign BRESP  = (state_q == WRESP && decerr_q) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: vector table plus arbitration and mid-burst reset sequences.
// Expectations for out-of-range addresses follow AXI_SRAM_SLAVE_DECERR_EN when defined.
module tb_axi_sram_slave;

  logic        ACLK = 0;
  logic        ARESETn = 0;
  logic [7:0]  AWID = 0;
  logic [31:0] AWADDR = 0;
  logic [3:0]  AWLEN = 0;
  logic [2:0]  AWSIZE = 3'd2;
  logic [1:0]  AWBURST = 2'd1;
  logic        AWVALID = 0;
  logic        AWREADY;
  logic [31:0] WDATA = 0;
  logic [3:0]  WSTRB = 0;
  logic        WLAST = 0;
  logic        WVALID = 0;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 0;
  logic [7:0]  ARID = 0;
  logic [31:0] ARADDR = 0;
  logic [3:0]  ARLEN = 0;
  logic [2:0]  ARSIZE = 3'd2;
  logic [1:0]  ARBURST = 2'd1;
  logic        ARVALID = 0;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 0;
  logic        CEB, WEB;
  logic [31:0] BWEB;
  logic [13:0] A;
  logic [31:0] DI;
  logic [31:0] sram_do = 0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:16383] = '{default: 32'h0};
  int sram_wr_cnt = 0;

  axi_sram_slave #(.SRAM_AW(14)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(sram_do)
  );

  always #5 ACLK = ~ACLK;

  // Behavioural SRAM: bit-masked write, one-cycle read latency.
  always @(posedge ACLK) begin
    if (CEB === 1'b0) begin
      if (WEB === 1'b0) begin
        mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
        sram_wr_cnt <= sram_wr_cnt + 1;
      end else begin
        sram_do <= mem[A];
      end
    end
  end

  typedef struct {
    bit          is_wr;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  strb;
    logic [31:0] bweb;
    logic [3:0]  rr_pat;
    logic [13:0] a0;
    logic [1:0]  resp;
    logic [3:0][31:0] d;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mkv(input bit wr, input logic [7:0] id, input logic [31:0] addr,
                               input logic [3:0] len, input logic [3:0] strb,
                               input logic [31:0] bweb, input logic [3:0] pat,
                               input logic [13:0] a0, input logic [1:0] resp,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
    vec_t v;
    v.is_wr = wr; v.id = id; v.addr = addr; v.len = len; v.strb = strb; v.bweb = bweb;
    v.rr_pat = pat; v.a0 = a0; v.resp = resp; v.d = {d3, d2, d1, d0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    int n = 0;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1; #1;
    while (!AWREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    chk("aw_accept", 32'(AWREADY), 32'h1);
    @(negedge ACLK);
    AWVALID = 0;
  endtask

  task automatic w_beats(input vec_t v);
    logic [13:0] ea;
    for (int b = 0; b <= int'(v.len); b++) begin
      @(negedge ACLK);
      WVALID = 1; WDATA = v.d[b]; WSTRB = v.strb; WLAST = (b == int'(v.len)); #1;
      ea = v.a0 + 14'(b);
      chk("w_wready", 32'(WREADY), 32'h1);
      chk("w_ceb", 32'(CEB), 32'h0);
      chk("w_web", 32'(WEB), 32'h0);
      chk("w_addr", 32'(A), 32'(ea));
      chk("w_bweb", BWEB, v.bweb);
      chk("w_di", DI, v.d[b]);
    end
  endtask

  task automatic b_phase(input logic [7:0] id, input logic [1:0] resp);
    @(negedge ACLK);
    WVALID = 0; WLAST = 0; #1;
    chk("b_valid", 32'(BVALID), 32'h1);
    chk("b_id", 32'(BID), 32'(id));
    chk("b_resp", 32'(BRESP), 32'(resp));
    chk("b_idle_ceb", 32'(CEB), 32'h1);
    chk("b_idle_bweb", BWEB, 32'hFFFF_FFFF);
    chk("b_wready", 32'(WREADY), 32'h0);
    @(negedge ACLK); #1;
    chk("b_hold", 32'(BVALID), 32'h1);
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0; #1;
    chk("b_done", 32'(BVALID), 32'h0);
    chk("b_awready", 32'(AWREADY), 32'h1);
  endtask

  task automatic ar_issue_check(input vec_t v);
    chk("ar_ceb", 32'(CEB), (v.resp == 2'b00) ? 32'h0 : 32'h1);
    chk("ar_web", 32'(WEB), 32'h1);
    if (v.resp == 2'b00) chk("ar_addr", 32'(A), 32'(v.a0));
    chk("ar_rvalid_early", 32'(RVALID), 32'h0);
  endtask

  task automatic ar_phase(input vec_t v);
    int n = 0;
    @(negedge ACLK);
    ARID = v.id; ARADDR = v.addr; ARLEN = v.len; ARVALID = 1; #1;
    while (!ARREADY && n < 20) begin @(negedge ACLK); #1; n++; end
    chk("ar_accept", 32'(ARREADY), 32'h1);
    @(negedge ACLK);
    ARVALID = 0; #1;
    ar_issue_check(v);
  endtask

  task automatic r_phase(input vec_t v);
    int b = 0;
    int cyc = 0;
    while (b <= int'(v.len) && cyc < 64) begin
      @(negedge ACLK);
      RREADY = v.rr_pat[cyc % 4]; #1;
      chk("r_valid", 32'(RVALID), 32'h1);
      chk("r_data", RDATA, v.d[b]);
      chk("r_last", 32'(RLAST), (b == int'(v.len)) ? 32'h1 : 32'h0);
      chk("r_id", 32'(RID), 32'(v.id));
      chk("r_resp", 32'(RRESP), 32'(v.resp));
      if (v.resp != 2'b00) chk("r_decerr_ceb", 32'(CEB), 32'h1);
      if (RREADY && RVALID) b++;
      cyc++;
    end
    chk("r_beats", 32'(b), 32'(v.len) + 32'h1);
    @(negedge ACLK);
    RREADY = 0; #1;
    chk("r_done", 32'(RVALID), 32'h0);
    chk("r_arready", 32'(ARREADY), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t sv;
    int wcnt;

    vecs[0] = mkv(1, 8'h12, 32'h10, 4'd0, 4'hF, 32'h0, 4'h0, 14'd4, 2'b00,
                  32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    vecs[1] = mkv(1, 8'h34, 32'h14, 4'd2, 4'hF, 32'h0, 4'h0, 14'd5, 2'b00,
                  32'h11111111, 32'h22222222, 32'h33333333, 32'h0);
    vecs[2] = mkv(0, 8'h56, 32'h10, 4'd3, 4'h0, 32'h0, 4'b1111, 14'd4, 2'b00,
                  32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333);
    vecs[3] = mkv(1, 8'h07, 32'h20, 4'd0, 4'b0101, 32'hFF00FF00, 4'h0, 14'd8, 2'b00,
                  32'hAABBCCDD, 32'h0, 32'h0, 32'h0);
    vecs[4] = mkv(0, 8'h9A, 32'h10, 4'd3, 4'h0, 32'h0, 4'b1001, 14'd4, 2'b00,
                  32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333);
    vecs[5] = mkv(0, 8'hBC, 32'h20, 4'd0, 4'h0, 32'h0, 4'b1111, 14'd8, 2'b00,
                  32'h00BB00DD, 32'h0, 32'h0, 32'h0);
    vecs[6] = mkv(1, 8'hC3, 32'hFFFC, 4'd1, 4'hF, 32'h0, 4'h0, 14'h3FFF, 2'b00,
                  32'h01020304, 32'h05060708, 32'h0, 32'h0);
    vecs[7] = mkv(0, 8'hC4, 32'hFFFC, 4'd1, 4'h0, 32'h0, 4'b1011, 14'h3FFF, 2'b00,
                  32'h01020304, 32'h05060708, 32'h0, 32'h0);
`ifdef AXI_SRAM_SLAVE_DECERR_EN
    vecs[8] = mkv(0, 8'h5A, 32'h0001_0010, 4'd0, 4'h0, 32'h0, 4'b1111, 14'd4, 2'b11,
                  32'h0, 32'h0, 32'h0, 32'h0);
    vecs[9] = mkv(0, 8'hA5, 32'h0002_0000, 4'd1, 4'h0, 32'h0, 4'b1101, 14'd0, 2'b11,
                  32'h0, 32'h0, 32'h0, 32'h0);
`else
    vecs[8] = mkv(0, 8'h5A, 32'h0001_0010, 4'd0, 4'h0, 32'h0, 4'b1111, 14'd4, 2'b00,
                  32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    vecs[9] = mkv(0, 8'hA5, 32'h0002_0000, 4'd1, 4'h0, 32'h0, 4'b1101, 14'd0, 2'b00,
                  32'h05060708, 32'h0, 32'h0, 32'h0);
`endif

    repeat (3) @(negedge ACLK);
    #1;
    chk("rst_awready", 32'(AWREADY), 32'h0);
    chk("rst_arready", 32'(ARREADY), 32'h0);
    chk("rst_wready", 32'(WREADY), 32'h0);
    chk("rst_bvalid", 32'(BVALID), 32'h0);
    chk("rst_rvalid", 32'(RVALID), 32'h0);
    chk("rst_rlast", 32'(RLAST), 32'h0);
    chk("rst_ceb", 32'(CEB), 32'h1);
    chk("rst_web", 32'(WEB), 32'h1);
    chk("rst_ids", {16'h0, BID, RID}, 32'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_resp", {28'h0, BRESP, RRESP}, 32'h0);
    @(negedge ACLK);
    ARESETn = 1; #1;
    chk("rel_awready", 32'(AWREADY), 32'h1);
    chk("rel_arready", 32'(ARREADY), 32'h1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        aw_phase(vecs[i].id, vecs[i].addr, vecs[i].len);
        w_beats(vecs[i]);
        b_phase(vecs[i].id, vecs[i].resp);
      end else begin
        ar_phase(vecs[i]);
        r_phase(vecs[i]);
      end
    end

    // Simultaneous AW and AR: write first, read accepted once B completes.
    sv = mkv(1, 8'h77, 32'h30, 4'd0, 4'hF, 32'h0, 4'b1111, 14'd12, 2'b00,
             32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    @(negedge ACLK);
    AWID = 8'h77; AWADDR = 32'h30; AWLEN = 0; AWVALID = 1;
    ARID = 8'h78; ARADDR = 32'h30; ARLEN = 0; ARVALID = 1; #1;
    chk("arb_awready", 32'(AWREADY), 32'h1);
    chk("arb_arready", 32'(ARREADY), 32'h0);
    @(negedge ACLK);
    AWVALID = 0; #1;
    chk("arb_wr_state", 32'(WREADY), 32'h1);
    chk("arb_ar_blocked", 32'(ARREADY), 32'h0);
    w_beats(sv);
    b_phase(8'h77, 2'b00);
    chk("arb_ar_after_b", 32'(ARREADY), 32'h1);
    sv.id = 8'h78;
    @(negedge ACLK);
    ARVALID = 0; #1;
    ar_issue_check(sv);
    r_phase(sv);

    // Reset during beat 2 of an 8-beat write.
    aw_phase(8'h99, 32'h100, 4'd7);
    for (int b = 0; b < 2; b++) begin
      @(negedge ACLK);
      WVALID = 1; WDATA = 32'h5555_0000 + 32'(b); WSTRB = 4'hF; WLAST = 0;
    end
    @(negedge ACLK);
    WDATA = 32'h5555_0002; #1;
    chk("mid_wready_pre", 32'(WREADY), 32'h1);
    wcnt = sram_wr_cnt;
    ARESETn = 0; #1;
    chk("mid_wready", 32'(WREADY), 32'h0);
    chk("mid_ceb", 32'(CEB), 32'h1);
    chk("mid_web", 32'(WEB), 32'h1);
    chk("mid_awready", 32'(AWREADY), 32'h0);
    repeat (3) @(negedge ACLK);
    #1;
    chk("mid_no_write", 32'(sram_wr_cnt), 32'(wcnt));
    chk("mid_mem_beat1", mem[14'h41], 32'h5555_0001);
    chk("mid_mem_beat2", mem[14'h42], 32'h0);
    @(negedge ACLK);
    WVALID = 0; ARESETn = 1; #1;
    chk("mid_rel_awready", 32'(AWREADY), 32'h1);
    chk("mid_rel_arready", 32'(ARREADY), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 The block SHALL have parameter SRAM_AW, default 14, giving the SRAM word-address width (64 KB).
REQ-002 The block SHALL have these clock and reset ports: ACLK input 1, the single clock; ARESETn input 1, the reset, asynchronous and active-low.
REQ-003 The block SHALL have these AXI write address ports: AWID in 8; AWADDR in 32; AWLEN in 4; AWSIZE in 3; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-004 The block SHALL have these AXI write data ports: WDATA in 32; WSTRB in 4; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-005 The block SHALL have these AXI write response ports: BID out 8; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-006 The block SHALL have these AXI read address ports: ARID in 8; ARADDR in 32; ARLEN in 4; ARSIZE in 3; ARBURST in 2; ARVALID in 1; ARREADY out 1.
REQ-007 The block SHALL have these AXI read data ports: RID out 8; RDATA out 32; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.
REQ-008 The block SHALL have these SRAM ports: CEB out 1 (chip enable, active-low); WEB out 1 (write enable, active-low); BWEB out 32 (bit write mask, active-low); A out SRAM_AW (word address); DI out 32 (write data); DO in 32 (read data, valid the cycle after a read with CEB=0, WEB=1).

Function
REQ-009 The block SHALL implement an FSM with states IDLE, RD, WR, WRESP, and SHALL hold at most one transaction outstanding.
REQ-010 In IDLE, AWREADY and ARREADY SHALL both be 1.
REQ-011 If AWVALID and ARVALID are both high in IDLE, the write SHALL be accepted, and ARREADY SHALL be 0 in that cycle.
REQ-012 On accept, the block SHALL latch the ID, address[SRAM_AW+1:2] and LEN, and SHALL clear a 4-bit beat counter.
REQ-013 Only INCR bursts of 4-byte size SHALL be supported; AWBURST, ARBURST, AWSIZE and ARSIZE SHALL be ignored, and the address SHALL increment by 1 word per beat, wrapping modulo 2^SRAM_AW.
REQ-014 Read timing: the block SHALL accept AR at edge T, drive the SRAM read for beat 0 (CEB=0, WEB=1) in cycle T+1, and assert RVALID from T+2.
REQ-015 RID, RDATA, RRESP and RLAST SHALL remain stable while RVALID=1 and RREADY=0, with DO captured into a hold register.
REQ-016 On a non-last R handshake, the SRAM read for the next beat SHALL be issued in the same cycle, so RVALID stays 1 with zero bubbles under continuous RREADY.
REQ-017 RLAST SHALL be 1 when the beat counter equals the latched ARLEN; the last R handshake SHALL return the FSM to IDLE.
REQ-018 In WR, WREADY SHALL be 1 and each W handshake SHALL write the SRAM in the same cycle: CEB=0, WEB=0, DI=WDATA, and BWEB byte n = {8{~WSTRB[n]}}.
REQ-019 A W handshake with WLAST=1 SHALL move the FSM to WRESP; WLAST alone SHALL terminate the burst regardless of AWLEN.
REQ-020 In WRESP, BVALID SHALL be 1, BID SHALL equal the latched AWID, and BVALID SHALL hold until BREADY; the handshake SHALL return the FSM to IDLE.
REQ-021 With no SRAM access, CEB SHALL be 1, WEB SHALL be 1 and BWEB SHALL be all-ones.
REQ-022 RRESP and BRESP SHALL be 2'b00 (OKAY) unless the configuration feature overrides them.

Reset
REQ-023 While ARESETn=0, the FSM SHALL be IDLE, and AWREADY, ARREADY, WREADY, BVALID and RVALID SHALL be 0.
REQ-024 While ARESETn=0, RLAST SHALL be 0, all ID, data and response outputs SHALL be 0, CEB SHALL be 1 and WEB SHALL be 1.
REQ-025 Reset asserted mid-burst SHALL abandon the transaction immediately with no further SRAM write.
REQ-026 AWREADY and ARREADY SHALL go to 1 in the first cycle after reset is released.

Configuration
REQ-027 When macro AXI_SRAM_SLAVE_DECERR_EN is defined, an accepted address with ADDR[31:SRAM_AW+2] != 0 SHALL return 2'b11 (DECERR) on every R beat and on B, and SHALL not access the SRAM (CEB=1).
REQ-028 In the DECERR case, RDATA SHALL be 0, and R/W beat counting and handshakes SHALL be unchanged.
REQ-029 When AXI_SRAM_SLAVE_DECERR_EN is not defined, the upper address bits SHALL be ignored and the response SHALL always be OKAY.

Verification
REQ-030 Single write AWID=8'h12, AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=4'hF -> SRAM A=4, BWEB=0, WEB=0 for one cycle; then BID=8'h12, BRESP=0.
REQ-031 4-beat read ARADDR=0x10, ARLEN=3, RREADY held 1 -> RVALID first high 2 cycles after accept; 4 consecutive beats with addresses 4..7; RLAST only on beat 3.
REQ-032 Read with RREADY toggling 1,0,0,1 -> RDATA is unchanged during stall cycles and no beat is skipped or duplicated.
REQ-033 AWVALID and ARVALID asserted together in IDLE -> write is served first; read is accepted after the B handshake.
REQ-034 WSTRB=4'b0101 -> BWEB=32'hFF00FF00.
REQ-035 ARESETn pulled low during beat 2 of an 8-beat write -> WREADY=0 at once and no SRAM write afterwards; with AXI_SRAM_SLAVE_DECERR_EN defined, ARADDR=0x0002_0000 -> RRESP=2'b11 and CEB stays 1.
